// File: rtl/i2s_rx_deserializer_if.sv
// ============================================================================
// Module   : i2s_rx_deserializer_if
// Purpose  : I2S pin bundle plus the parallel stereo sample bus it produces.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface i2s_rx_deserializer_if #(
  parameter int DATA_W = 24
);
  logic              I2S_sclk;
  logic              I2S_ws;
  logic              I2S_data;
  logic [DATA_W-1:0] lft_smpl;
  logic [DATA_W-1:0] rght_smpl;
  logic              vld;
  logic              frm_err;
  logic              locked;

  // Receiver side: consumes the pins, drives the sample bus.
  modport slave (
    input  I2S_sclk, I2S_ws, I2S_data,
    output lft_smpl, rght_smpl, vld, frm_err, locked
  );

  // Source/consumer side: drives the pins, observes the sample bus.
  modport master (
    output I2S_sclk, I2S_ws, I2S_data,
    input  lft_smpl, rght_smpl, vld, frm_err, locked
  );
endinterface

`default_nettype wire

// File: rtl/i2s_rx_deserializer.sv
// ============================================================================
// Module   : i2s_rx_deserializer
// Purpose  : Oversampled I2S receiver producing left/right pairs with lock and
//            short-word / stalled-clock detection.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2s_rx_deserializer #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  wire logic              clk,
  input  wire logic              rst,
  i2s_rx_deserializer_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sclk_hist;

  logic                   sclk_s;
  logic                   ws_s;
  logic                   data_s;
  logic                   sclk_rise;
  logic                   ws_edge;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [DATA_W-1:0]      shreg;
  logic [DATA_W-1:0]      left_hold;
  logic [DATA_W-1:0]      shift_in;
  logic                   ws_prev;
  logic                   pair_done;

  logic [DATA_W-1:0]      lft_smpl;
  logic [DATA_W-1:0]      rght_smpl;
  logic                   vld;
  logic                   frm_err;
  logic                   locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ws_sync   <= '0;
      data_sync <= '0;
      sclk_hist <= 1'b0;
    end else begin
      sclk_sync[0] <= bus.I2S_sclk;
      ws_sync[0]   <= bus.I2S_ws;
      data_sync[0] <= bus.I2S_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        ws_sync[i]   <= ws_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ws_s      = ws_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ws_edge   = sclk_rise & (ws_s != ws_prev);
  assign shift_in  = {shreg[DATA_W-2:0], data_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      shreg     <= '0;
      left_hold <= '0;
      ws_prev   <= 1'b0;
      pair_done <= 1'b0;
      lft_smpl  <= '0;
      rght_smpl <= '0;
      vld       <= 1'b0;
      frm_err   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      vld     <= 1'b0;
      frm_err <= 1'b0;

      // Publish the pair one clk after the last right bit so both halves move together.
      if (pair_done) begin
        lft_smpl  <= left_hold;
        rght_smpl <= shreg;
        vld       <= 1'b1;
        locked    <= 1'b1;
        pair_done <= 1'b0;
      end

      if (sclk_rise) begin
        to_cnt  <= '0;
        ws_prev <= ws_s;
        case (state)
          SYNC: begin
            if (ws_edge && !ws_s) begin
              state   <= LEFT;
              bit_cnt <= '0;
            end
          end
          LEFT: begin
            if (ws_edge) begin
              if (bit_cnt == CNT_FULL) begin
                state   <= RIGHT;
                bit_cnt <= '0;
              end else begin
                frm_err <= 1'b1;
                locked  <= 1'b0;
                state   <= SYNC;
              end
            end else if (bit_cnt != CNT_FULL) begin
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_LAST) begin
                left_hold <= shift_in;
              end
            end
          end
          RIGHT: begin
            if (ws_edge) begin
              // A short right word drops the pair, but this edge still opens a left word.
              if (bit_cnt != CNT_FULL) begin
                frm_err <= 1'b1;
                locked  <= 1'b0;
              end
              state   <= LEFT;
              bit_cnt <= '0;
            end else if (bit_cnt != CNT_FULL) begin
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_LAST) begin
                pair_done <= 1'b1;
              end
            end
          end
          default: state <= SYNC;
        endcase
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_LAST && state != SYNC) begin
          frm_err <= 1'b1;
          locked  <= 1'b0;
          state   <= SYNC;
        end
      end
    end
  end

  assign bus.lft_smpl  = lft_smpl;
  assign bus.rght_smpl = rght_smpl;
  assign bus.vld       = vld;
  assign bus.frm_err   = frm_err;
  assign bus.locked    = locked;

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_deserializer.sv
// ============================================================================
// Module   : tb_i2s_rx_deserializer
// Purpose  : Directed, table-driven bench for the I2S receiver.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_rx_deserializer;

  localparam int DATA_W      = 24;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 200;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int TO_LAT      = SYNC_STAGES + 1 + TIMEOUT;
  localparam int HALF        = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2s_rx_deserializer_if #(.DATA_W(DATA_W)) bus ();

  i2s_rx_deserializer #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    int                llen;
    int                rlen;
    bit                mid_locked;
    int                d_vld;
    int                d_err;
    logic [DATA_W-1:0] exp_l;
    logic [DATA_W-1:0] exp_r;
    bit                exp_locked;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int vld_cyc = -1;
  int err_cyc = -1;
  int last_rise = 0;
  int rise24 = 0;
  logic [DATA_W-1:0] got_l = '0;
  logic [DATA_W-1:0] got_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clk step; outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.vld === 1'b1) begin
      vld_cnt++;
      vld_cyc = cyc;
      got_l   = bus.lft_smpl;
      got_r   = bus.rght_smpl;
    end
    if (bus.frm_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  endtask

  // Bit 0 is the slot where ws changes (previous word's LSB); bits 1..DATA_W carry val.
  task automatic send_word(input logic w, input logic [DATA_W-1:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      bus.I2S_sclk = 1'b0;
      bus.I2S_ws   = w;
      bus.I2S_data = (i >= 1 && i <= DATA_W) ? val[DATA_W-i] : 1'b0;
      repeat (HALF) tick();
      bus.I2S_sclk = 1'b1;
      last_rise = cyc;
      if (i == DATA_W) rise24 = cyc;
      repeat (HALF) tick();
    end
  endtask

  task automatic do_reset();
    bus.I2S_sclk = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   v0, e0, nz, n;

    tbl[0] = '{24'h123456, 24'hABCDEF, 32, 32, 1'b0, 1, 0, 24'h123456, 24'hABCDEF, 1'b1};
    tbl[1] = '{24'h5A5A5A, 24'hA5A5A5, 32, 32, 1'b1, 1, 0, 24'h5A5A5A, 24'hA5A5A5, 1'b1};
    tbl[2] = '{24'h111111, 24'h222222, 32, 16, 1'b1, 0, 0, 24'h5A5A5A, 24'hA5A5A5, 1'b1};
    tbl[3] = '{24'h7FFFFF, 24'h800000, 32, 32, 1'b0, 1, 1, 24'h7FFFFF, 24'h800000, 1'b1};
    tbl[4] = '{24'h800000, 24'h7FFFFF, 32, 32, 1'b1, 1, 0, 24'h800000, 24'h7FFFFF, 1'b1};
    tbl[5] = '{24'h333333, 24'h444444, 16, 32, 1'b1, 0, 1, 24'h800000, 24'h7FFFFF, 1'b0};
    tbl[6] = '{24'h0F0F0F, 24'hF0F0F0, 32, 32, 1'b0, 1, 0, 24'h0F0F0F, 24'hF0F0F0, 1'b1};

    bus.I2S_sclk = 1'b0;
    bus.I2S_ws   = 1'b0;
    bus.I2S_data = 1'b0;
    rst = 1'b1;

    // Reset, then idle pins
    repeat (3) tick();
    check("reset_lft", bus.lft_smpl, 0);
    check("reset_rght", bus.rght_smpl, 0);
    check("reset_flags", {bus.vld, bus.frm_err, bus.locked}, 0);
    rst = 1'b0;
    nz = 0;
    repeat (100) begin
      tick();
      if (bus.lft_smpl !== '0 || bus.rght_smpl !== '0 || bus.locked !== 1'b0) nz++;
    end
    check("idle_outputs_zero", nz, 0);
    check("idle_vld_count", vld_cnt, 0);
    check("idle_err_count", err_cnt, 0);

    // Leading right word so the first left start is a genuine ws fall
    send_word(1'b1, '0, 32);

    for (int k = 0; k < 7; k++) begin
      v0 = vld_cnt;
      e0 = err_cnt;
      send_word(1'b0, tbl[k].l, tbl[k].llen);
      check($sformatf("row%0d_mid_locked", k), bus.locked, tbl[k].mid_locked);
      send_word(1'b1, tbl[k].r, tbl[k].rlen);
      check($sformatf("row%0d_vld_count", k), vld_cnt - v0, tbl[k].d_vld);
      check($sformatf("row%0d_err_count", k), err_cnt - e0, tbl[k].d_err);
      check($sformatf("row%0d_lft", k), bus.lft_smpl, tbl[k].exp_l);
      check($sformatf("row%0d_rght", k), bus.rght_smpl, tbl[k].exp_r);
      check($sformatf("row%0d_locked", k), bus.locked, tbl[k].exp_locked);
      if (tbl[k].d_vld == 1) begin
        check($sformatf("row%0d_vld_latency", k), vld_cyc - rise24, LAT);
        check($sformatf("row%0d_vld_lft", k), got_l, tbl[k].exp_l);
      end
    end

    // Stalled bit clock after lock
    bus.I2S_sclk = 1'b0;
    e0 = err_cnt;
    n  = 0;
    while (err_cnt == e0 && n < TIMEOUT + 100) begin
      tick();
      n++;
    end
    check("timeout_err_seen", err_cnt - e0, 1);
    check("timeout_latency", err_cyc - last_rise, TO_LAT);
    check("timeout_locked", bus.locked, 0);
    repeat (TIMEOUT + 20) tick();
    check("timeout_no_repeat", err_cnt - e0, 1);
    v0 = vld_cnt;
    send_word(1'b1, '0, 8);
    send_word(1'b0, 24'h246801, 32);
    send_word(1'b1, 24'h13579B, 32);
    check("resync_vld_count", vld_cnt - v0, 1);
    check("resync_lft", bus.lft_smpl, 24'h246801);
    check("resync_rght", bus.rght_smpl, 24'h13579B);
    check("resync_locked", bus.locked, 1);

    // Reset in the middle of a right word
    send_word(1'b0, 24'hABCABC, 32);
    send_word(1'b1, '0, 12);
    v0 = vld_cnt;
    e0 = err_cnt;
    do_reset();
    check("rst_right_outputs", {bus.lft_smpl, bus.locked}, 0);
    send_word(1'b1, '0, 20);
    send_word(1'b0, 24'h000ABC, 32);
    check("rst_right_no_early_vld", vld_cnt - v0, 0);
    send_word(1'b1, 24'hFED000, 32);
    check("rst_right_first_lft", got_l, 24'h000ABC);
    check("rst_right_first_rght", got_r, 24'hFED000);
    send_word(1'b0, 24'h654321, 32);
    send_word(1'b1, 24'h0A0B0C, 32);
    check("rst_right_vld_count", vld_cnt - v0, 2);
    check("rst_right_err_count", err_cnt - e0, 0);
    check("rst_right_second_lft", bus.lft_smpl, 24'h654321);
    check("rst_right_second_rght", bus.rght_smpl, 24'h0A0B0C);

    // Reset during bit 10 of a left word
    send_word(1'b0, 24'h999999, 10);
    v0 = vld_cnt;
    e0 = err_cnt;
    do_reset();
    send_word(1'b0, '0, 10);
    send_word(1'b1, '0, 32);
    send_word(1'b0, 24'h000001, 32);
    check("rst_left_no_stale_vld", vld_cnt - v0, 0);
    send_word(1'b1, 24'hFFFFFF, 32);
    check("rst_left_vld_count", vld_cnt - v0, 1);
    check("rst_left_err_count", err_cnt - e0, 0);
    check("rst_left_lft", got_l, 24'h000001);
    check("rst_left_rght", got_r, 24'hFFFFFF);
    check("rst_left_locked", bus.locked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_rx_deserializer.md
Name: i2s_rx_deserializer

Overview:
- Front end of the Equalizer audio path, directly downstream of the RN52 I2S pins (I2S_sclk, I2S_ws, I2S_data).
- Oversamples the slow I2S bit clock with the 50 MHz system clock and deserializes standard-justified I2S frames into parallel left/right sample pairs.
- Emits one valid strobe per stereo pair to the FIR band filters.
- Tracks frame lock; flags short words and a stalled bit clock.

Parameters:
- DATA_W, 24, bits captured per channel word (MSB first); later bits in the slot are ignored.
- SYNC_STAGES, 2, metastability flops on each I2S input before edge detection.
- TIMEOUT, 4096, clk cycles without an I2S_sclk rising edge before lock is dropped.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- I2S_sclk  in  1  asynchronous I2S bit clock from the RN52.
- I2S_ws  in  1  asynchronous word select; 0 = left, 1 = right.
- I2S_data  in  1  asynchronous serial data, MSB first.
- lft_smpl  out  DATA_W  left sample of the last complete pair, two's complement.
- rght_smpl  out  DATA_W  right sample of the last complete pair.
- vld  out  1  one-clk pulse; lft_smpl/rght_smpl updated in the same cycle.
- frm_err  out  1  one-clk pulse on a short word or timeout.
- locked  out  1  high from the first vld until error, timeout or rst.

Behaviour:
- Reset:
  - rst is sampled on the clk rising edge only.
  - All outputs, shift register, bit counter, timeout counter and left hold register go to 0.
  - State goes to SYNC.
  - Synchronizer flops clear to 0.
  - rst mid-frame discards partial data; no vld or frm_err is issued for it.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then one edge-history flop.
  - sclk_rise is a one-clk event when the synced sclk was 0 and is now 1.
  - All I2S activity is evaluated only on sclk_rise cycles.
  - ws and data are sampled from the synced copies in the sclk_rise cycle.
- Word timing (standard I2S):
  - A ws transition is detected at the sclk_rise where sampled ws differs from the previous sampled ws. Call this rise R.
  - The bit at R is the previous word's LSB slot. It is not captured for the new word.
  - The new word's MSB is sampled at rise R+1.
  - Bits R+1 through R+DATA_W are shifted in, MSB first. Further rises are ignored until the next ws transition.
- States:
  - SYNC: ignore data. A ws 1→0 transition → LEFT, bit counter = 0. A 0→1 transition stays in SYNC, so capture always starts on a left word.
  - LEFT: shift bits. When the counter reaches DATA_W, copy the shift register to the left hold register.
    - ws 0→1 with counter == DATA_W → RIGHT, counter cleared.
    - ws 0→1 with counter < DATA_W → frm_err pulse, locked = 0, go to SYNC.
  - RIGHT: shift bits. When the counter reaches DATA_W, in the next clk:
    - lft_smpl takes the left hold register and rght_smpl takes the shift register, updated together;
    - vld = 1 for exactly one cycle; locked = 1.
  - RIGHT transitions:
    - ws 1→0 with the word complete → LEFT.
    - ws 1→0 with the word short → frm_err pulse, locked = 0, pair discarded, enter LEFT. That transition is itself a valid left start.
- Latency:
  - vld is asserted 1 clk after the sclk_rise cycle that samples the DATA_W-th right bit.
  - That is SYNC_STAGES+2 clks after the pin-level sclk edge.
- Outputs hold their last value between vld pulses. Outputs are never partially updated.
- Timeout:
  - A counter increments every clk and clears on each sclk_rise.
  - On reaching TIMEOUT while state != SYNC: frm_err pulse, locked = 0, state → SYNC, counter saturates.
  - In SYNC the counter saturates silently, with no frm_err.
- Simultaneous events:
  - A ws transition at the same rise as the DATA_W-th bit cannot occur, since R+DATA_W > R.
  - A timeout in the same cycle as sclk_rise: sclk_rise wins and the counter is cleared.
  - rst overrides everything.
- Bit counter width is clog2(DATA_W+1) and it saturates at DATA_W.

Test Plan:
1. rst held 3 clks, then I2S idle for 100 clks → all outputs 0, no vld, no frm_err.
2. sclk period 20 clk, 32-bit slots. Left 0x123456 followed by 8 zero pad bits, right 0xABCDEF followed by 8 pad bits → exactly one vld; lft_smpl = 0x123456, rght_smpl = 0xABCDEF; locked = 1; vld lands SYNC_STAGES+2 clks after the 24th right-bit sclk edge.
3. Release rst while ws = 1, mid right word, then send 2 full frames → no vld until the first left word completes; exactly 2 vld pulses with correct values.
4. After lock, send a right word only 16 bits long before ws falls → one frm_err, no vld for that pair, locked = 0. Next full frame (0x7FFFFF, 0x800000) → vld with those values, locked = 1.
5. After lock, stop sclk → frm_err pulses exactly TIMEOUT clks after the last sclk rise; locked = 0. Restart sclk → resync on the first ws fall.
6. Assert rst during bit 10 of a left word, release, then send a full frame (0x000001, 0xFFFFFF) → no stale vld; first vld carries 0x000001 and 0xFFFFFF.
